// File: rtl/pc_sequencer_pkg.sv
// Shared types and default addresses for the fetch-stage PC sequencer.
package pc_sequencer_pkg;

    typedef logic [31:0] word_t;

    localparam word_t DEF_RESET_PC = 32'h0000_3000;
    localparam word_t DEF_EXC_PC   = 32'h0000_4180;
    localparam word_t DEF_IMEM_LO  = 32'h0000_3000;
    localparam word_t DEF_IMEM_HI  = 32'h0000_6FFC;

    typedef enum logic [1:0] {
        PCS_BOOT  = 2'd0,
        PCS_RUN   = 2'd1,
        PCS_DRAIN = 2'd2
    } pcs_e;

endpackage

// File: rtl/pc_addr_check.sv
// Fetch address checker: flags misaligned or out-of-window instruction addresses.
module pc_addr_check
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] IMEM_LO = DEF_IMEM_LO,
    parameter logic [31:0] IMEM_HI = DEF_IMEM_HI
) (
    input  logic [31:0] addr,
    output logic        adel
);

    assign adel = (addr[1:0] != 2'b00) | (addr < IMEM_LO) | (addr > IMEM_HI);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with stall hold, exception/ERET redirect and a
// one-cycle drain after every redirect that masks stale CP0 requests.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_PC   = DEF_EXC_PC,
    parameter logic [31:0] IMEM_LO  = DEF_IMEM_LO,
    parameter logic [31:0] IMEM_HI  = DEF_IMEM_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] npc,
    input  logic        is_ctrl,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        pc_adel,
    output logic        bd_d,
    output logic        flush,
    output logic [1:0]  state
);

    pcs_e  cur_state;
    pcs_e  nxt_state;
    word_t pc_q;
    logic  bd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= PCS_BOOT;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // The unused encoding falls through to BOOT so a corrupted state self-heals.
    always_comb begin
        nxt_state = PCS_BOOT;
        case (cur_state)
            PCS_BOOT:  nxt_state = PCS_RUN;
            PCS_RUN:   nxt_state = (exc_req | eret_req) ? PCS_DRAIN : PCS_RUN;
            PCS_DRAIN: nxt_state = PCS_RUN;
            default:   nxt_state = PCS_BOOT;
        endcase
    end

    always_comb begin
        flush = 1'b0;
        case (cur_state)
            PCS_BOOT: flush = 1'b1;
            PCS_RUN:  flush = exc_req | eret_req;
            default:  flush = 1'b0;
        endcase
    end

    // Redirects only land from RUN; DRAIN deliberately ignores CP0 requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
            bd_q <= 1'b0;
        end else begin
            case (cur_state)
                PCS_RUN: begin
                    if (exc_req) begin
                        pc_q <= EXC_PC;
                        bd_q <= 1'b0;
                    end else if (eret_req) begin
                        pc_q <= epc;
                        bd_q <= 1'b0;
                    end else if (!stall) begin
                        pc_q <= npc;
                        bd_q <= is_ctrl;
                    end
                end
                PCS_DRAIN: begin
                    if (!stall) begin
                        pc_q <= npc;
                        bd_q <= is_ctrl;
                    end
                end
                default: begin
                    pc_q <= pc_q;
                    bd_q <= bd_q;
                end
            endcase
        end
    end

    pc_addr_check #(
        .IMEM_LO(IMEM_LO),
        .IMEM_HI(IMEM_HI)
    ) u_addr_check (
        .addr(pc_q),
        .adel(pc_adel)
    );

    assign pc    = pc_q;
    assign pc4   = pc_q + 32'd4;
    assign bd_d  = bd_q;
    assign state = cur_state;

endmodule
